// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode-0 (CPOL=0, CPHA=0) MSB-first master byte transceiver.
// Latency: done_o rises 1 + (2*DATA_W+1)*DIV clk_i cycles after the start_i edge.
// Backpressure: none. start_i is taken only in IDLE and is dropped otherwise (no queuing).
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i, tx_data_i   start pulse and byte to send (latched when accepted)
//   cs_hold_i            sampled in the DONE cycle; 1 keeps cs_n_o asserted after the byte
//   miso_i               serial data from the slave
//   sclk_o, mosi_o       SPI clock (idle low) and serial data to the slave
//   cs_n_o               active-low chip select
//   busy_o, done_o       transfer in progress / one-cycle end-of-byte pulse
//   rx_data_o            received byte, updated in the DONE cycle and held otherwise
module spi_byte_engine #(
  parameter int DIV    = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              cs_hold_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  localparam int PH_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              phase_end;

  assign phase_end = (phase_cnt == PH_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
      cs_n_o    <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (start_i) begin
            tx_sh   <= tx_data_i;
            bit_cnt <= '0;
            state   <= SETUP;
            // cs_n_o may already be low from a held previous byte; driving 0 again keeps it glitch-free.
            cs_n_o  <= 1'b0;
            busy_o  <= 1'b1;
            sclk_o  <= 1'b0;
            mosi_o  <= tx_data_i[DATA_W-1];
          end
        end

        SETUP: begin
          if (phase_end) begin
            phase_cnt <= '0;
            state     <= SCK_HI;
            sclk_o    <= 1'b1;
            // Sample on the same edge that raises SCLK: the slave has had a full phase to settle.
            rx_sh     <= {rx_sh[DATA_W-2:0], miso_i};
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        SCK_HI: begin
          if (phase_end) begin
            phase_cnt <= '0;
            state     <= SCK_LO;
            sclk_o    <= 1'b0;
            // Advance MOSI on the falling edge; after the last bit it simply holds.
            if (bit_cnt != BC_LAST) begin
              tx_sh  <= tx_sh << 1;
              mosi_o <= tx_sh[DATA_W-2];
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        SCK_LO: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (bit_cnt == BC_LAST) begin
              state     <= DONE;
              done_o    <= 1'b1;
              rx_data_o <= rx_sh;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= SCK_HI;
              sclk_o  <= 1'b1;
              rx_sh   <= {rx_sh[DATA_W-2:0], miso_i};
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
          if (!cs_hold_i) begin
            cs_n_o <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: directed bench for spi_byte_engine (DIV=4 main instance, DIV=2 second instance).
// Cycle k of a transfer is the clk period that ends at edge N+k, where N is the edge accepting start_i;
// outputs are sampled at the falling clk edge inside that period.
module tb_spi_byte_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       cs_hold;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  logic       start2;
  logic [7:0] tx_data2;
  logic       cs_hold2;
  logic       miso2;
  logic       sclk2;
  logic       mosi2;
  logic       cs_n2;
  logic       busy2;
  logic       done2;
  logic [7:0] rx_data2;

  // Slave side: 0 = loopback of mosi, 1 = tied high, 2 = slave shift register (MSB first).
  logic [1:0] miso_mode;
  logic [7:0] slave_sh;

  int n_checks;
  int n_fail;

  assign miso  = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b1 : slave_sh[7];
  assign miso2 = mosi2;

  spi_byte_engine #(.DIV(4), .DATA_W(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .tx_data_i (tx_data),
    .cs_hold_i (cs_hold),
    .miso_i    (miso),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .cs_n_o    (cs_n),
    .busy_o    (busy),
    .done_o    (done),
    .rx_data_o (rx_data)
  );

  spi_byte_engine #(.DIV(2), .DATA_W(8)) dut2 (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start2),
    .tx_data_i (tx_data2),
    .cs_hold_i (cs_hold2),
    .miso_i    (miso2),
    .sclk_o    (sclk2),
    .mosi_o    (mosi2),
    .cs_n_o    (cs_n2),
    .busy_o    (busy2),
    .done_o    (done2),
    .rx_data_o (rx_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // Runs one transfer on the DIV=4 instance and reports what was observed.
  task automatic do_xfer(
    input  logic [7:0] tx,
    input  logic       hold,
    input  logic [1:0] mmode,
    input  logic [7:0] slave,
    input  bit         repulse,
    output int         done_k,
    output int         done_cnt,
    output logic [7:0] rx_at,
    output logic [7:0] cap,
    output int         rises,
    output int         busy_low_k,
    output bit         cs_all_low,
    output logic       cs_after
  );
    logic prev_sclk;
    done_k     = 0;
    done_cnt   = 0;
    rx_at      = 8'h00;
    cap        = 8'h00;
    rises      = 0;
    busy_low_k = 0;
    cs_all_low = 1'b1;
    cs_after   = 1'bx;
    miso_mode  = mmode;
    slave_sh   = slave;
    tx_data    = tx;
    cs_hold    = hold;
    start      = 1'b1;
    prev_sclk  = sclk;
    @(posedge clk);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (repulse && k == 10) begin
        start   = 1'b1;
        tx_data = 8'h00;
      end
      if (repulse && k == 11) start = 1'b0;
      if (sclk && !prev_sclk) begin
        rises++;
        cap = {cap[6:0], mosi};
      end
      if (!sclk && prev_sclk && mmode == 2'd2) slave_sh = slave_sh << 1;
      prev_sclk = sclk;
      if (!busy && busy_low_k == 0) busy_low_k = k;
      if (done_k != 0 && k == done_k + 1) begin
        cs_after = cs_n;
        start    = 1'b0;
        break;
      end
      if (done) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k;
          rx_at  = rx_data;
        end
        if (repulse) begin
          start   = 1'b1;
          tx_data = 8'h00;
        end
      end
      if (cs_n) cs_all_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    tx_data  = 8'h00;
    cs_hold  = 1'b0;
    miso_mode = 2'd1;
    slave_sh = 8'h00;
    start2   = 1'b0;
    tx_data2 = 8'h00;
    cs_hold2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({sclk, mosi, cs_n, busy, done} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_ctrl: sclk,mosi,cs_n,busy,done = %b, required 00100", {sclk, mosi, cs_n, busy, done});
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx: rx_data = %h, required 00", rx_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sclk, cs_n, busy, done, sclk2, cs_n2, busy2, done2} !== 8'b01000100) begin
      n_fail++;
      $display("FAIL idle_after_reset: ctrl bits = %b, required 01000100",
               {sclk, cs_n, busy, done, sclk2, cs_n2, busy2, done2});
    end
  endtask

  task automatic test_loopback_a5();
    int dk, dc, rs, bl;
    logic [7:0] rx, cp;
    bit cl;
    logic ca;
    do_xfer(8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (dk !== 69) begin n_fail++; $display("FAIL a5_done_cycle: done at %0d, required 69", dk); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL a5_done_count: %0d pulses, required 1", dc); end
    n_checks++;
    if (rx !== 8'hA5) begin n_fail++; $display("FAIL a5_rx: rx_data = %h, required a5", rx); end
    n_checks++;
    if (cp !== 8'hA5) begin n_fail++; $display("FAIL a5_mosi_bits: captured %h, required a5", cp); end
    n_checks++;
    if (rs !== 8) begin n_fail++; $display("FAIL a5_sclk_rises: %0d, required 8", rs); end
    n_checks++;
    if (cl !== 1'b1 || ca !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_cs: low_during=%b after=%b, required 1 1", cl, ca);
    end
    n_checks++;
    if (mosi !== 1'b1 || rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_idle_hold: mosi=%b rx=%h, required 1 a5", mosi, rx_data);
    end
  endtask

  task automatic test_miso_high();
    int dk, dc, rs, bl;
    logic [7:0] rx, cp;
    bit cl;
    logic ca;
    do_xfer(8'h3C, 1'b0, 2'd1, 8'h00, 1'b0, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (rx !== 8'hFF) begin n_fail++; $display("FAIL 3c_rx: rx_data = %h, required ff", rx); end
    n_checks++;
    if (cp !== 8'h3C) begin n_fail++; $display("FAIL 3c_mosi_bits: captured %h, required 3c", cp); end
    n_checks++;
    if (bl !== 70) begin n_fail++; $display("FAIL 3c_busy_span: busy first low at %0d, required 70", bl); end
    n_checks++;
    if (dk !== 69) begin n_fail++; $display("FAIL 3c_done_cycle: done at %0d, required 69", dk); end
  endtask

  task automatic test_ignored_start();
    int dk, dc, rs, bl, extra;
    logic [7:0] rx, cp;
    bit cl;
    logic ca;
    do_xfer(8'hC3, 1'b0, 2'd0, 8'h00, 1'b1, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (dk !== 69 || dc !== 1) begin
      n_fail++;
      $display("FAIL repulse_done: done at %0d count %0d, required 69 1", dk, dc);
    end
    n_checks++;
    if (rx !== 8'hC3 || cp !== 8'hC3) begin
      n_fail++;
      $display("FAIL repulse_data: rx=%h mosi=%h, required c3 c3", rx, cp);
    end
    extra = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy || !cs_n) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL repulse_no_second: %0d active cycles after done, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int dk, dc, rs, bl;
    logic [7:0] rx, cp;
    bit cl;
    logic ca;
    do_xfer(8'h12, 1'b1, 2'd2, 8'h9A, 1'b0, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (rx !== 8'h9A || cp !== 8'h12) begin
      n_fail++;
      $display("FAIL b2b_first_data: rx=%h mosi=%h, required 9a 12", rx, cp);
    end
    n_checks++;
    if (cl !== 1'b1 || ca !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first_cs: low_during=%b after=%b, required 1 0", cl, ca);
    end
    do_xfer(8'h34, 1'b0, 2'd2, 8'hBC, 1'b0, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (rx !== 8'hBC || cp !== 8'h34 || dk !== 69) begin
      n_fail++;
      $display("FAIL b2b_second_data: rx=%h mosi=%h done=%0d, required bc 34 69", rx, cp, dk);
    end
    n_checks++;
    if (cl !== 1'b1 || ca !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_cs: low_during=%b after=%b, required 1 1", cl, ca);
    end
  endtask

  task automatic test_reset_mid();
    int dk, dc, rs, bl, nr, bad;
    logic [7:0] rx, cp;
    bit cl, hit;
    logic ca, prev;
    miso_mode = 2'd0;
    tx_data   = 8'hF0;
    cs_hold   = 1'b0;
    start     = 1'b1;
    prev      = sclk;
    nr        = 0;
    hit       = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !prev) nr++;
      prev = sclk;
      if (nr == 4 && sclk) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: bit 3 high phase not seen, rises=%0d", nr); end
    n_checks++;
    if (rx_data !== 8'hBC) begin n_fail++; $display("FAIL rstmid_pre_rx: rx_data = %h, required bc", rx_data); end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sclk, mosi, cs_n, busy, done} !== 5'b00100 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_immediate: sclk,mosi,cs_n,busy,done=%b rx=%h, required 00100 00",
               {sclk, mosi, cs_n, busy, done}, rx_data);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || sclk) bad++;
    end
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy || sclk) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_no_done: %0d active cycles, required 0", bad); end
    do_xfer(8'h81, 1'b0, 2'd0, 8'h00, 1'b0, dk, dc, rx, cp, rs, bl, cl, ca);
    n_checks++;
    if (dk !== 69 || rx !== 8'h81 || rs !== 8) begin
      n_fail++;
      $display("FAIL rstmid_fresh: done=%0d rx=%h rises=%0d, required 69 81 8", dk, rx, rs);
    end
  endtask

  task automatic test_div2();
    int done_k, rises, last, bad;
    logic prev;
    logic [7:0] rx_at;
    done_k   = 0;
    rises    = 0;
    last     = 1;
    bad      = 0;
    rx_at    = 8'h00;
    tx_data2 = 8'h6D;
    start2   = 1'b1;
    prev     = sclk2;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (sclk2 !== prev) begin
        if (sclk2) rises++;
        if (k - last != 2) bad++;
        last = k;
      end
      prev = sclk2;
      if (done2 && done_k == 0) begin
        done_k = k;
        rx_at  = rx_data2;
      end
      if (done_k != 0 && k > done_k) break;
    end
    n_checks++;
    if (done_k !== 35) begin n_fail++; $display("FAIL div2_done_cycle: done at %0d, required 35", done_k); end
    n_checks++;
    if (rises !== 8 || bad !== 0) begin
      n_fail++;
      $display("FAIL div2_half_period: rises=%0d bad_lengths=%0d, required 8 0", rises, bad);
    end
    n_checks++;
    if (rx_at !== 8'h6D) begin n_fail++; $display("FAIL div2_rx: rx_data = %h, required 6d", rx_at); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_loopback_a5();
    test_miso_high();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_div2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
